// File: rtl/cache_array_mw.sv
// Multi-way, byte-maskable cache storage array with registered read and a sequential clear engine.
// Optional macro ARRAY_BYPASS_EN: same-index read returns the byte-merged write data for loaded ways.
module cache_array_mw #(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 256,
    parameter int WAYS    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    output logic                    busy,
    input  logic                    rd_en,
    input  logic [S_INDEX-1:0]      rindex,
    output logic                    rvalid,
    output logic [WAYS*WIDTH-1:0]   dataout,
    input  logic [WAYS-1:0]         load,
    input  logic [S_INDEX-1:0]      windex,
    input  logic [WIDTH/8-1:0]      wmask,
    input  logic [WIDTH-1:0]        datain
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int NBYTES   = WIDTH / 8;
    localparam int CTR_W    = S_INDEX + 1;

    if (WIDTH % 8 != 0) begin : g_width_check
        $error("cache_array_mw: WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CTR_W-1:0]       clr_ctr_q, clr_ctr_d;
    logic                   busy_q, busy_d;
    logic                   rvalid_q, rvalid_d;
    logic [WAYS*WIDTH-1:0]  dataout_q, dataout_d;
    logic                   last_set;

    logic [WIDTH-1:0]       mem_q [WAYS][NUM_SETS];
    logic [WIDTH-1:0]       mem_d [WAYS];
    logic [WAYS-1:0]        mem_we;
    logic [S_INDEX-1:0]     mem_idx;
    logic [WIDTH-1:0]       merged [WAYS];

    assign last_set = (clr_ctr_q == CTR_W'(NUM_SETS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (flush)    state_d = CLEAR;
            CLEAR: if (last_set) state_d = IDLE;
        endcase
    end

    // Byte-merge of the write data over the currently stored entry at windex, per way.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            merged[w] = mem_q[w][windex];
            for (int b = 0; b < NBYTES; b++) begin
                if (wmask[b]) begin
                    merged[w][8*b +: 8] = datain[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        clr_ctr_d = clr_ctr_q;
        busy_d    = (state_d == CLEAR);
        rvalid_d  = 1'b0;
        dataout_d = dataout_q;
        mem_we    = '0;
        mem_idx   = windex;
        for (int w = 0; w < WAYS; w++) begin
            mem_d[w] = merged[w];
        end
        case (state_q)
            IDLE: begin
                if (flush) begin
                    clr_ctr_d = '0;
                end
                mem_we = load;
                if (rd_en) begin
                    rvalid_d = 1'b1;
                    for (int w = 0; w < WAYS; w++) begin
`ifdef ARRAY_BYPASS_EN
                        if (load[w] && (windex == rindex)) begin
                            dataout_d[w*WIDTH +: WIDTH] = merged[w];
                        end else begin
                            dataout_d[w*WIDTH +: WIDTH] = mem_q[w][rindex];
                        end
`else
                        dataout_d[w*WIDTH +: WIDTH] = mem_q[w][rindex];
`endif
                    end
                end
            end
            CLEAR: begin
                clr_ctr_d = clr_ctr_q + CTR_W'(1);
                mem_we    = '1;
                mem_idx   = clr_ctr_q[S_INDEX-1:0];
                for (int w = 0; w < WAYS; w++) begin
                    mem_d[w] = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ctr_q <= '0;
            busy_q    <= 1'b1;
            rvalid_q  <= 1'b0;
            dataout_q <= '0;
        end else begin
            clr_ctr_q <= clr_ctr_d;
            busy_q    <= busy_d;
            rvalid_q  <= rvalid_d;
            dataout_q <= dataout_d;
        end
    end

    // Storage has no reset of its own; the clear engine zeroes it after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                if (mem_we[w]) begin
                    mem_q[w][mem_idx] <= mem_d[w];
                end
            end
        end
    end

    assign busy    = busy_q;
    assign rvalid  = rvalid_q;
    assign dataout = dataout_q;

endmodule

// File: tb/tb_cache_array_mw.sv
// Scoreboard bench for cache_array_mw (S_INDEX=3, WIDTH=256, WAYS=2); honours ARRAY_BYPASS_EN.
module tb_cache_array_mw;

    typedef logic [511:0] dword_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         busy;
    logic         rd_en;
    logic [2:0]   rindex;
    logic         rvalid;
    logic [511:0] dataout;
    logic [1:0]   load;
    logic [2:0]   windex;
    logic [31:0]  wmask;
    logic [255:0] datain;

    dword_t exp_q[$];
    int     tests;
    int     fails;

    logic [255:0] val_a;
    logic [255:0] val_b;
    logic [255:0] val_c;
    logic [255:0] val_d;
    logic [255:0] way0_ab;
    logic [255:0] way1_b;

    cache_array_mw #(.S_INDEX(3), .WIDTH(256), .WAYS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .busy    (busy),
        .rd_en   (rd_en),
        .rindex  (rindex),
        .rvalid  (rvalid),
        .dataout (dataout),
        .load    (load),
        .windex  (windex),
        .wmask   (wmask),
        .datain  (datain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input dword_t act, input dword_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest expected read result.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rvalid actual=1 required=0");
            end else begin
                checkOutput("read_data", dataout, exp_q.pop_front());
            end
        end
    end

    task automatic idleInputs();
        flush  = 1'b0;
        rd_en  = 1'b0;
        rindex = '0;
        load   = '0;
        windex = '0;
        wmask  = '0;
        datain = '0;
    endtask

    // Drives one cycle of stimulus starting at posedge+1, then returns inputs to idle.
    task automatic applyStimulus(input bit rd, input logic [2:0] ri, input logic [1:0] ld,
                                 input logic [2:0] wi, input logic [31:0] wm,
                                 input logic [255:0] di, input bit fl,
                                 input bit expect_read, input dword_t exp);
        rd_en  = rd;
        rindex = ri;
        load   = ld;
        windex = wi;
        wmask  = wm;
        datain = di;
        flush  = fl;
        if (expect_read) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic readSet(input logic [2:0] ri, input dword_t exp);
        applyStimulus(1'b1, ri, 2'b00, 3'd0, 32'h0, 256'h0, 1'b0, 1'b1, exp);
    endtask

    task automatic writeSet(input logic [1:0] ld, input logic [2:0] wi,
                            input logic [31:0] wm, input logic [255:0] di);
        applyStimulus(1'b0, 3'd0, ld, wi, wm, di, 1'b0, 1'b0, '0);
    endtask

    // Counts cycles with busy high, optionally hammering reads/writes or flush meanwhile.
    task automatic countBusy(input bit junk, input bit fl, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            flush = fl;
            if (junk) begin
                rd_en  = 1'b1;
                rindex = 3'd5;
                load   = 2'b11;
                windex = 3'd3;
                wmask  = 32'hFFFF_FFFF;
                datain = val_c;
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        tests   = 0;
        fails   = 0;
        val_a   = {8{32'hAAAA_5555}};
        val_b   = {8{32'h1234_5678}};
        val_c   = {8{32'hC3C3_3C3C}};
        val_d   = {8{32'h0F0F_F0F0}};
        way0_ab = {{7{32'hAAAA_5555}}, 32'h1234_5678};
        way1_b  = {224'h0, 32'h1234_5678};
        idleInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset and initial clear");
        checkOutput("reset_busy", dword_t'(busy), dword_t'(1));
        checkOutput("reset_rvalid", dword_t'(rvalid), dword_t'(0));
        checkOutput("reset_dataout", dataout, '0);
        countBusy(1'b0, 1'b0, cnt);
        checkOutput("reset_clear_cycles", dword_t'(cnt), dword_t'(8));
        for (int i = 0; i < 8; i++) readSet(3'(i), '0);

        $display("[TB] single-way write and read");
        writeSet(2'b01, 3'd5, 32'hFFFF_FFFF, val_a);
        readSet(3'd5, {256'h0, val_a});

        $display("[TB] byte-masked write to both ways");
        writeSet(2'b11, 3'd5, 32'h0000_000F, val_b);
        readSet(3'd5, {way1_b, way0_ab});

        $display("[TB] same-index read and write");
`ifdef ARRAY_BYPASS_EN
        applyStimulus(1'b1, 3'd5, 2'b01, 3'd5, 32'hFFFF_FFFF, val_c, 1'b0, 1'b1, {way1_b, val_c});
`else
        applyStimulus(1'b1, 3'd5, 2'b01, 3'd5, 32'hFFFF_FFFF, val_c, 1'b0, 1'b1, {way1_b, way0_ab});
`endif
        readSet(3'd5, {way1_b, val_c});

        $display("[TB] different-index read and write, zero mask, back-to-back reads");
        applyStimulus(1'b1, 3'd5, 2'b10, 3'd2, 32'hFFFF_FFFF, val_d, 1'b0, 1'b1, {way1_b, val_c});
        writeSet(2'b11, 3'd2, 32'h0, val_a);
        readSet(3'd2, {val_d, 256'h0});
        readSet(3'd5, {way1_b, val_c});
        readSet(3'd2, {val_d, 256'h0});

        $display("[TB] flush with traffic");
        applyStimulus(1'b1, 3'd2, 2'b01, 3'd6, 32'hFFFF_FFFF, val_a, 1'b1, 1'b1, {val_d, 256'h0});
        checkOutput("flush_busy", dword_t'(busy), dword_t'(1));
        countBusy(1'b1, 1'b0, cnt);
        checkOutput("flush_clear_cycles", dword_t'(cnt), dword_t'(8));
        checkOutput("dataout_hold", dataout, {val_d, 256'h0});
        for (int i = 0; i < 8; i++) readSet(3'(i), '0);

        $display("[TB] reset mid-clear and flush during clear");
        writeSet(2'b11, 3'd7, 32'hFFFF_FFFF, val_a);
        readSet(3'd7, {val_a, val_a});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        countBusy(1'b0, 1'b1, cnt);
        checkOutput("restart_clear_cycles", dword_t'(cnt), dword_t'(8));
        for (int i = 0; i < 8; i++) readSet(3'(i), '0);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("scoreboard_drained", dword_t'(exp_q.size()), dword_t'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
